// File: rtl/seq_pkg.sv
// Shared types and helpers for the code sequencer: FSM states, code width
// and the wrap-around arithmetic used on every advance.
package seq_pkg;

  localparam int unsigned CODE_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } state_e;

  // Count up, wrapping from max back to 0.
  function automatic logic [CODE_W-1:0] next_up(input logic [CODE_W-1:0] code,
                                                input logic [CODE_W-1:0] max);
    return (code >= max) ? '0 : code + CODE_W'(1);
  endfunction

  // Count down, wrapping from 0 up to max.
  function automatic logic [CODE_W-1:0] next_down(input logic [CODE_W-1:0] code,
                                                  input logic [CODE_W-1:0] max);
    return (code == '0) ? max : code - CODE_W'(1);
  endfunction

  // Limit a loaded value to the legal code range.
  function automatic logic [CODE_W-1:0] clamp(input logic [CODE_W-1:0] val,
                                              input logic [CODE_W-1:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the terminal count.
// The count is held while disabled so a paused sequence resumes mid-period.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last = (r_count == LAST);
  assign o_tick = i_en && w_last;

  // Prescaler count: clear wins over enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_last ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/code_sequencer.sv
// Source stage for the 5-bit seven-segment decoder: steps a code through
// 0..MAX_CODE on a programmable timebase with run/pause/step/load control.
module code_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DIV      = 4,
  parameter int unsigned MAX_CODE = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              dir,
  input  logic              load,
  input  logic [CODE_W-1:0] load_val,
  output logic              b5,
  output logic              b4,
  output logic              b3,
  output logic              b2,
  output logic              b1,
  output logic              code_upd,
  output logic              running
);

  localparam logic [CODE_W-1:0] MAX_C = CODE_W'(MAX_CODE);

  state_e            r_state;
  logic [CODE_W-1:0] r_code;
  logic              r_upd;
  logic              r_running;

  logic              w_en;
  logic              w_clear;
  logic              w_tick;
  logic              w_adv;
  logic [CODE_W-1:0] w_next_code;

  // Prescaler only runs in RUN on cycles not pre-empted by load or stop.
  assign w_en    = (r_state == StRun) && !load && !stop;
  // Restart the period on load, on entry to RUN from IDLE, and on going idle.
  assign w_clear = load
                || (start && !stop && (r_state == StIdle))
                || (stop && (r_state == StPause));

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_en    (w_en),
    .o_tick  (w_tick)
  );

  // Step is only meaningful outside RUN; tick is already RUN-qualified.
  assign w_adv       = (step && (r_state != StRun)) || w_tick;
  assign w_next_code = dir ? next_down(r_code, MAX_C) : next_up(r_code, MAX_C);

  // Control FSM with the code register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_code    <= '0;
      r_upd     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (load) begin
        r_code <= clamp(load_val, MAX_C);
        r_upd  <= 1'b1;
      end else if (stop) begin
        case (r_state)
          StRun:   r_state <= StPause;
          StPause: r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
        r_running <= 1'b0;
      end else if (start && (r_state != StRun)) begin
        r_state   <= StRun;
        r_running <= 1'b1;
      end else if (w_adv) begin
        r_code <= w_next_code;
        r_upd  <= 1'b1;
      end
    end
  end

  assign b5       = r_code[0];
  assign b4       = r_code[1];
  assign b3       = r_code[2];
  assign b2       = r_code[3];
  assign b1       = r_code[4];
  assign code_upd = r_upd;
  assign running  = r_running;

endmodule
